// File: rtl/nanorv32_irq_pkg.sv
// rtl/nanorv32_irq_pkg.sv - shared FSM encoding, register indices and CTRL bit positions
package nanorv32_irq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_ACTIVE = 2'd2
  } irq_state_e;

  localparam logic [1:0] REG_ENABLE  = 2'd0;
  localparam logic [1:0] REG_PENDING = 2'd1;
  localparam logic [1:0] REG_MODE    = 2'd2;
  localparam logic [1:0] REG_CTRL    = 2'd3;

  localparam int CTRL_GIE_BIT    = 0;
  localparam int CTRL_ID_LSB     = 4;
  localparam int CTRL_ACTIVE_BIT = 8;
  localparam int CTRL_REQ_BIT    = 9;

endpackage

// File: rtl/nanorv32_irq_prio_enc.sv
// rtl/nanorv32_irq_prio_enc.sv - lowest-index-wins priority encoder
module nanorv32_irq_prio_enc #(
  parameter int NB_IRQ = 8
) (
  input  logic [NB_IRQ-1:0] req,
  output logic              valid,
  output logic [2:0]        id
);

  // Scan from the top down so the lowest set index is the last one written
  always_comb begin
    valid = 1'b0;
    id    = 3'd0;
    for (int i = NB_IRQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        valid = 1'b1;
        id    = i[2:0];
      end
    end
  end

endmodule

// File: rtl/nanorv32_irq_ctrl.sv
// rtl/nanorv32_irq_ctrl.sv - edge/level interrupt capture, register file and req/ack/done handshake
module nanorv32_irq_ctrl
  import nanorv32_irq_pkg::*;
#(
  parameter int NB_IRQ = 8  // at most 8 so the source index fits irq_id
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic [NB_IRQ-1:0] irqs,
  input  logic              reg_sel,
  input  logic              reg_we,
  input  logic [1:0]        reg_addr,
  input  logic [31:0]       reg_wdata,
  output logic [31:0]       reg_rdata,
  output logic              reg_ready,
  output logic              irq_req,
  output logic [2:0]        irq_id,
  input  logic              irq_ack,
  input  logic              irq_done
);

  logic [NB_IRQ-1:0] irq_q, irq_qq;
  logic [NB_IRQ-1:0] enable_q, enable_d, mode_q, mode_d, pend_edge_q, pend_edge_d;
  logic              gie_q, gie_d, ready_q, ready_d;
  logic [31:0]       rdata_q, rdata_d, rd_val;
  irq_state_e        state_q, state_d;
  logic [2:0]        id_q, id_d;

  logic [NB_IRQ-1:0] rise, pend_vis, cand, id_onehot, w1c, ack_clr;
  logic              sel_valid, ack_take, latched_cand;
  logic [2:0]        sel_id;
  logic              unused_wdata;

  assign unused_wdata = ^reg_wdata;

  // Derived candidate view: level sources follow the synchronised line, edge sources use the sticky bit
  always_comb begin
    rise     = irq_q & ~irq_qq;
    pend_vis = (mode_q & pend_edge_q) | (~mode_q & irq_q);
    cand     = pend_vis & enable_q & {NB_IRQ{gie_q}};
    for (int i = 0; i < NB_IRQ; i++) begin
      id_onehot[i] = (id_q == i[2:0]);
    end
    ack_take     = (state_q == ST_REQ) && irq_ack;
    latched_cand = |(cand & id_onehot);
    ack_clr      = ack_take ? id_onehot : '0;
  end

  nanorv32_irq_prio_enc #(.NB_IRQ(NB_IRQ)) u_prio_enc (
    .req   (cand),
    .valid (sel_valid),
    .id    (sel_id)
  );

  // Register writes, W1C/ack clearing of edge pendings (a same-cycle edge wins) and read mux
  always_comb begin
    enable_d = enable_q;
    mode_d   = mode_q;
    gie_d    = gie_q;
    w1c      = '0;
    rd_val   = '0;
    if (reg_sel && reg_we) begin
      case (reg_addr)
        REG_ENABLE:  enable_d = reg_wdata[NB_IRQ-1:0];
        REG_PENDING: w1c      = reg_wdata[NB_IRQ-1:0];
        REG_MODE:    mode_d   = reg_wdata[NB_IRQ-1:0];
        REG_CTRL:    gie_d    = reg_wdata[CTRL_GIE_BIT];
      endcase
    end
    pend_edge_d = ((pend_edge_q & ~w1c & ~ack_clr) | rise) & mode_q;
    case (reg_addr)
      REG_ENABLE:  rd_val[NB_IRQ-1:0] = enable_q;
      REG_PENDING: rd_val[NB_IRQ-1:0] = pend_vis;
      REG_MODE:    rd_val[NB_IRQ-1:0] = mode_q;
      REG_CTRL: begin
        rd_val[CTRL_GIE_BIT]        = gie_q;
        rd_val[CTRL_ID_LSB +: 3]    = id_q;
        rd_val[CTRL_ACTIVE_BIT]     = (state_q == ST_ACTIVE);
        rd_val[CTRL_REQ_BIT]        = (state_q == ST_REQ);
      end
    endcase
    ready_d = reg_sel;
    rdata_d = (reg_sel && !reg_we) ? rd_val : 32'd0;
  end

  // Next state: latch the winner in IDLE, never preempt, ack beats withdraw
  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    case (state_q)
      ST_IDLE: begin
        if (sel_valid) begin
          state_d = ST_REQ;
          id_d    = sel_id;
        end
      end
      ST_REQ: begin
        if (irq_ack)            state_d = ST_ACTIVE;
        else if (!latched_cand) state_d = ST_IDLE;
      end
      ST_ACTIVE: begin
        if (irq_done) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded from registered state
  always_comb begin
    irq_req   = (state_q == ST_REQ);
    irq_id    = id_q;
    reg_ready = ready_q;
    reg_rdata = rdata_q;
  end

  // All state flops
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      irq_q       <= '0;
      irq_qq      <= '0;
      enable_q    <= '0;
      mode_q      <= '0;
      pend_edge_q <= '0;
      gie_q       <= 1'b0;
      ready_q     <= 1'b0;
      rdata_q     <= '0;
      state_q     <= ST_IDLE;
      id_q        <= 3'd0;
    end else begin
      irq_q       <= irqs;
      irq_qq      <= irq_q;
      enable_q    <= enable_d;
      mode_q      <= mode_d;
      pend_edge_q <= pend_edge_d;
      gie_q       <= gie_d;
      ready_q     <= ready_d;
      rdata_q     <= rdata_d;
      state_q     <= state_d;
      id_q        <= id_d;
    end
  end

endmodule

// File: tb/tb_nanorv32_irq_ctrl.sv
// tb/tb_nanorv32_irq_ctrl.sv - scoreboard bench for nanorv32_irq_ctrl
module tb_nanorv32_irq_ctrl;

  localparam int NB_IRQ = 8;
  localparam logic [1:0] A_EN = 2'd0, A_PEND = 2'd1, A_MODE = 2'd2, A_CTRL = 2'd3;

  logic              clk_in = 1'b0;
  logic              rst;
  logic [NB_IRQ-1:0] irqs;
  logic              reg_sel, reg_we;
  logic [1:0]        reg_addr;
  logic [31:0]       reg_wdata, reg_rdata;
  logic              reg_ready, irq_req, irq_ack, irq_done;
  logic [2:0]        irq_id;

  typedef struct {
    string       name;
    logic [31:0] val;
  } rd_exp_t;

  rd_exp_t    rd_q[$];
  logic [2:0] id_q[$];
  rd_exp_t    rd_cur;
  logic [2:0] id_cur, id_held;
  logic       req_prev = 1'b0;
  int         checks = 0;
  int         errors = 0;

  nanorv32_irq_ctrl #(.NB_IRQ(NB_IRQ)) dut (
    .clk_in    (clk_in),
    .rst       (rst),
    .irqs      (irqs),
    .reg_sel   (reg_sel),
    .reg_we    (reg_we),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_rdata (reg_rdata),
    .reg_ready (reg_ready),
    .irq_req   (irq_req),
    .irq_id    (irq_id),
    .irq_ack   (irq_ack),
    .irq_done  (irq_done)
  );

  always #5 clk_in = ~clk_in;

  // Monitor: pops expectations whenever the DUT presents a register response or a new request
  always @(negedge clk_in) begin
    if (reg_ready) begin
      checks++;
      if (rd_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_reg_ready: rdata=%h, no access outstanding", reg_rdata);
      end else begin
        rd_cur = rd_q.pop_front();
        if (reg_rdata !== rd_cur.val) begin
          errors++;
          $display("FAIL %s: rdata=%h expected=%h", rd_cur.name, reg_rdata, rd_cur.val);
        end
      end
    end
    if (irq_req && !req_prev) begin
      checks++;
      if (id_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_irq_req: irq_id=%0d, no request expected", irq_id);
      end else begin
        id_cur = id_q.pop_front();
        if (irq_id !== id_cur) begin
          errors++;
          $display("FAIL irq_id: got=%0d expected=%0d", irq_id, id_cur);
        end
      end
      id_held = irq_id;
    end else if (irq_req && req_prev) begin
      checks++;
      if (irq_id !== id_held) begin
        errors++;
        $display("FAIL irq_id_stable: got=%0d expected=%0d", irq_id, id_held);
      end
    end
    req_prev = irq_req;
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic reg_wr(input logic [1:0] a, input logic [31:0] d, input string n);
    rd_q.push_back('{n, 32'd0});
    reg_sel = 1'b1; reg_we = 1'b1; reg_addr = a; reg_wdata = d;
    tick();
    reg_sel = 1'b0; reg_we = 1'b0;
    tick();
  endtask

  task automatic reg_rd(input logic [1:0] a, input logic [31:0] exp, input string n);
    rd_q.push_back('{n, exp});
    reg_sel = 1'b1; reg_we = 1'b0; reg_addr = a;
    tick();
    reg_sel = 1'b0;
    tick();
  endtask

  task automatic pulse_irq(input logic [NB_IRQ-1:0] v);
    irqs = v;
    tick();
    irqs = '0;
  endtask

  task automatic pulse_ack();
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
  endtask

  task automatic pulse_done();
    irq_done = 1'b1;
    tick();
    irq_done = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; irqs = '0; reg_sel = 0; reg_we = 0; reg_addr = '0; reg_wdata = '0;
    irq_ack = 0; irq_done = 0;
    tick(); tick();
    chk("rst_irq_req", 32'(irq_req), 32'd0);
    chk("rst_irq_id", 32'(irq_id), 32'd0);
    chk("rst_reg_ready", 32'(reg_ready), 32'd0);
    chk("rst_reg_rdata", reg_rdata, 32'd0);
    rst = 1'b0;
    tick();
    reg_rd(A_EN, 32'h0, "rst_enable");
    reg_rd(A_PEND, 32'h0, "rst_pending");
    reg_rd(A_MODE, 32'h0, "rst_mode");
    reg_rd(A_CTRL, 32'h0, "rst_ctrl");

    // Edge flow on source 0
    reg_wr(A_MODE, 32'h01, "wr_mode");
    reg_wr(A_EN, 32'h01, "wr_enable");
    reg_wr(A_CTRL, 32'h01, "wr_ctrl");
    id_q.push_back(3'd0);
    pulse_irq(8'h01);
    tick();
    chk("edge_req_e1", 32'(irq_req), 32'd0);
    tick();
    chk("edge_req_e2", 32'(irq_req), 32'd1);
    reg_rd(A_CTRL, 32'h201, "edge_ctrl_req");
    pulse_ack();
    chk("edge_req_after_ack", 32'(irq_req), 32'd0);
    reg_rd(A_PEND, 32'h00, "edge_pend_after_ack");
    reg_rd(A_CTRL, 32'h101, "edge_ctrl_active");
    pulse_done();
    reg_rd(A_CTRL, 32'h001, "edge_ctrl_idle");

    // Priority without preemption: 3 first, then 1
    reg_wr(A_MODE, 32'h0A, "wr_mode");
    reg_wr(A_EN, 32'h0A, "wr_enable");
    id_q.push_back(3'd3);
    pulse_irq(8'h08);
    tick(); tick();
    pulse_irq(8'h02);
    tick(); tick();
    chk("noprempt_id", 32'(irq_id), 32'd3);
    reg_rd(A_PEND, 32'h0A, "prio_pend_both");
    pulse_ack();
    reg_rd(A_PEND, 32'h02, "prio_pend_after_ack");
    reg_rd(A_CTRL, 32'h131, "prio_ctrl_active3");
    id_q.push_back(3'd1);
    pulse_done();
    tick();
    chk("prio_second_req", 32'(irq_req), 32'd1);
    pulse_ack();
    pulse_done();

    // Withdraw by disabling source 2 while requested
    reg_wr(A_MODE, 32'h04, "wr_mode");
    reg_wr(A_EN, 32'h04, "wr_enable");
    id_q.push_back(3'd2);
    pulse_irq(8'h04);
    tick(); tick();
    chk("wd_req_up", 32'(irq_req), 32'd1);
    reg_wr(A_EN, 32'h00, "wr_enable_off");
    chk("wd_req_down", 32'(irq_req), 32'd0);
    reg_rd(A_CTRL, 32'h021, "wd_ctrl_idle");
    reg_rd(A_PEND, 32'h04, "wd_pend_kept");
    reg_wr(A_PEND, 32'h04, "w1c_pend2");
    reg_rd(A_PEND, 32'h00, "wd_pend_cleared");

    // Level mode on source 4
    reg_wr(A_MODE, 32'h00, "wr_mode");
    reg_wr(A_EN, 32'h10, "wr_enable");
    id_q.push_back(3'd4);
    irqs = 8'h10;
    tick(); tick();
    chk("lvl_req", 32'(irq_req), 32'd1);
    pulse_ack();
    id_q.push_back(3'd4);
    pulse_done();
    tick();
    chk("lvl_rereq", 32'(irq_req), 32'd1);
    reg_wr(A_PEND, 32'h10, "w1c_level");
    reg_rd(A_PEND, 32'h10, "lvl_w1c_noeffect");
    pulse_ack();
    irqs = '0;
    pulse_done();
    tick(); tick();
    chk("lvl_no_req", 32'(irq_req), 32'd0);
    reg_rd(A_PEND, 32'h00, "lvl_pend_dropped");

    // Set wins over a same-cycle W1C on source 5
    reg_wr(A_EN, 32'h00, "wr_enable");
    reg_wr(A_MODE, 32'h20, "wr_mode");
    pulse_irq(8'h20);
    reg_wr(A_PEND, 32'h20, "w1c_vs_set");
    reg_rd(A_PEND, 32'h20, "set_wins");
    reg_wr(A_PEND, 32'h20, "w1c_plain");
    reg_rd(A_PEND, 32'h00, "w1c_clears");

    // Async reset while ACTIVE on source 6
    reg_wr(A_MODE, 32'h40, "wr_mode");
    reg_wr(A_EN, 32'h40, "wr_enable");
    id_q.push_back(3'd6);
    pulse_irq(8'h40);
    tick(); tick();
    pulse_ack();
    reg_rd(A_CTRL, 32'h161, "ctrl_active6");
    @(posedge clk_in);
    #3 rst = 1'b1;
    #1;
    chk("arst_irq_id", 32'(irq_id), 32'd0);
    chk("arst_irq_req", 32'(irq_req), 32'd0);
    chk("arst_reg_ready", 32'(reg_ready), 32'd0);
    chk("arst_reg_rdata", reg_rdata, 32'd0);
    tick();
    rst = 1'b0;
    tick();
    pulse_done();
    reg_rd(A_CTRL, 32'h000, "arst_ctrl");
    reg_rd(A_EN, 32'h000, "arst_enable");
    tick(); tick();
    chk("arst_no_req", 32'(irq_req), 32'd0);

    tick(); tick();
    chk("rd_queue_empty", 32'(rd_q.size()), 32'd0);
    chk("id_queue_empty", 32'(id_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/nanorv32_irq_ctrl.md
# nanorv32_irq_ctrl

Interrupt controller sitting between the interrupt mapper's 8-bit `irqs` vector and the nanorv32 core. Captures each line in per-source edge or level mode, holds pending/enable state in a small memory-mapped register file, and selects the highest-priority pending, enabled source (lowest index wins). It then presents that source to the core through a request/acknowledge/done handshake. Non-nesting: only one interrupt is in service at a time.

## Interface
Parameters:
- `NB_IRQ`, 8: number of interrupt lines; must be ≤ 8 so `irq_id` fits 3 bits.

Ports:
- `clk_in`  in  1  system clock.
- `rst`  in  1  reset; asynchronous, active-high.
- `irqs`  in  NB_IRQ  raw interrupt lines from the mapper (clk_in domain).
- `reg_sel`  in  1  register access strobe, one cycle per access.
- `reg_we`  in  1  1 = write, 0 = read (qualified by `reg_sel`).
- `reg_addr`  in  2  word index: 0 ENABLE, 1 PENDING, 2 MODE, 3 CTRL/STATUS.
- `reg_wdata`  in  32  write data.
- `reg_rdata`  out  32  read data, valid while `reg_ready` = 1, else 0.
- `reg_ready`  out  1  access complete, pulses one cycle after `reg_sel`.
- `irq_req`  out  1  interrupt request to core.
- `irq_id`  out  3  source index; stable while `irq_req` = 1 and while in ACTIVE.
- `irq_ack`  in  1  core takes the interrupt (single-cycle pulse).
- `irq_done`  in  1  core returned from handler (single-cycle pulse).

## Operation
- Input stage: `irq_q <= irqs`, `irq_qq <= irq_q`. A rising edge is `irq_q & ~irq_qq`.
- MODE[i] = 1 selects edge mode; MODE[i] = 0 selects level mode.
  - Edge mode: PENDING[i] sets on a rising edge. It clears on a W1C write to PENDING, or on `irq_ack` while `irq_id` = i. If set and clear occur in the same cycle, set wins.
  - Level mode: PENDING[i] = `irq_q[i]`. W1C writes and ack have no effect.
- Register map:
  - ENABLE: RW, bits [NB_IRQ-1:0].
  - PENDING: read gives pending bits; write is W1C.
  - MODE: RW.
  - CTRL/STATUS: bit0 GIE (RW); bits [6:4] current `irq_id` (RO); bit8 ACTIVE (RO); bit9 REQ (RO).
  - Unused bits read 0.
- Candidate = PENDING & ENABLE & {GIE}; selected source = lowest set index.
- FSM states IDLE, REQ, ACTIVE:
  - IDLE: `irq_req` = 0. If any candidate: latch `irq_id` = selected index and go to REQ.
  - REQ: `irq_req` = 1, `irq_id` frozen. A higher-priority source arriving does not preempt.
    - `irq_ack`: go to ACTIVE and clear the edge pending bit.
    - Else if the latched source is no longer a candidate (disabled, cleared, GIE = 0, level dropped): go to IDLE (withdraw).
    - If ack and withdraw occur in the same cycle, ack wins.
  - ACTIVE: `irq_req` = 0, `irq_id` held. `irq_done` returns to IDLE. New pends accumulate meanwhile.
  - `irq_ack` outside REQ and `irq_done` outside ACTIVE are ignored.
- Reset mid-operation returns to IDLE immediately, regardless of handshake state.

## Timing
- Reset values: ENABLE = 0, PENDING = 0, MODE = 0, GIE = 0, `irq_q`/`irq_qq` = 0, state = IDLE, `irq_req` = 0, `irq_id` = 0, `reg_ready` = 0, `reg_rdata` = 0.
- Edge latency: `irqs[i]` high before edge E0; PENDING set after E1; `irq_req` high after E2.
- Level latency: PENDING set after E0; `irq_req` high after E1.
- Ack: `irq_req` low the cycle after the `irq_ack` edge.
- After done: the next request can assert 1 cycle after the `irq_done` edge (IDLE evaluates, then REQ).
- Register writes take effect at the `reg_sel` edge. Reads sample state at that edge and return data with `reg_ready` the next cycle.
- No back-to-back pipelining is required; a `reg_sel` during `reg_ready` is accepted.

## Structure
- Shared package `nanorv32_irq_pkg`:
  - FSM state encoding.
  - Register index constants (ENABLE = 0, PENDING = 1, MODE = 2, CTRL = 3).
  - CTRL bit positions.
- Sub-module `nanorv32_irq_prio_enc`: combinational lowest-index priority encoder, NB_IRQ → {valid, id[2:0]}.

## Test plan
- Edge flow: MODE = 0x01, ENABLE = 0x01, GIE = 1; pulse `irqs[0]` for 1 cycle. Expect `irq_req` = 1 and `irq_id` = 0 two edges later. On `irq_ack`: PENDING = 0, STATUS.ACTIVE = 1. On `irq_done`: IDLE.
- Priority/no-preempt: sources 1 and 3 enabled in edge mode; raise 3, then 1 while in REQ. Expect `irq_id` stays 3. After ack/done, `irq_id` = 1 is requested.
- Withdraw: source 2 in REQ; write ENABLE = 0. Expect `irq_req` low the next cycle and the FSM in IDLE. PENDING[2] remains 1.
- Level mode: MODE[4] = 0, hold `irqs[4]` = 1. Ack/done leads to re-request. Drop the line, then PENDING[4] = 0 and no request follows. A W1C write to PENDING[4] while the line is high reads back 1.
- Set-vs-clear: W1C PENDING[5] in the same cycle as a rising edge on line 5. Expect PENDING[5] = 1.
- Async reset asserted in ACTIVE: all outputs go to reset values immediately; stray `irq_done` after reset is ignored.
